// File: rtl/traffic_light.sv
// Two-way intersection signal controller: HG -> HY -> VG -> VY phase sequencer
// with lamp-test and dual-yellow flash overrides and a registered countdown.
module traffic_light #(
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 5,
  parameter int TEST_COUNT  = 88
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       test,
  input  logic       flicker,
  output logic       hr,
  output logic       hy,
  output logic       hg,
  output logic       vr,
  output logic       vy,
  output logic       vg,
  output logic [7:0] count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HG   = 3'd1,
    HY   = 3'd2,
    VG   = 3'd3,
    VY   = 3'd4
  } state_t;

  localparam logic [7:0] GREEN_C  = 8'(GREEN_TIME);
  localparam logic [7:0] YELLOW_C = 8'(YELLOW_TIME);
  localparam logic [7:0] TEST_C   = 8'(TEST_COUNT);

  state_t      state_r, state_s;
  logic [7:0]  count_r, count_s;
  logic        blink_r, blink_s;
  logic [5:0]  lamps_r, lamps_s;  // {hr, hy, hg, vr, vy, vg}

  function automatic state_t next_phase(input state_t st);
    case (st)
      HG:      next_phase = HY;
      HY:      next_phase = VG;
      VG:      next_phase = VY;
      VY:      next_phase = HG;
      default: next_phase = HG;
    endcase
  endfunction

  function automatic logic [7:0] phase_time(input state_t st);
    case (st)
      HG, VG:  phase_time = GREEN_C;
      HY, VY:  phase_time = YELLOW_C;
      default: phase_time = 8'd0;
    endcase
  endfunction

  // The crossing direction is always red while the other side runs.
  function automatic logic [5:0] lamp_map(input state_t st);
    case (st)
      HG:      lamp_map = 6'b001_100;
      HY:      lamp_map = 6'b010_100;
      VG:      lamp_map = 6'b100_001;
      VY:      lamp_map = 6'b100_010;
      default: lamp_map = 6'b000_000;
    endcase
  endfunction

  // Mode priority and phase sequencing; blink only survives consecutive flash cycles.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    blink_s = 1'b0;
    lamps_s = 6'b000_000;
    if (!test) begin
      state_s = IDLE;
      count_s = TEST_C;
      lamps_s = 6'b111_111;
    end else if (flicker) begin
      state_s = IDLE;
      count_s = 8'd0;
      blink_s = ~blink_r;
      lamps_s = {1'b0, ~blink_r, 1'b0, 1'b0, ~blink_r, 1'b0};
    end else begin
      case (state_r)
        IDLE: begin
          state_s = HG;
          count_s = GREEN_C;
        end
        HG, HY, VG, VY: begin
          if (count_r > 8'd1) begin
            count_s = count_r - 8'd1;
          end else begin
            state_s = next_phase(state_r);
            count_s = phase_time(next_phase(state_r));
          end
        end
        default: begin
          state_s = HG;
          count_s = GREEN_C;
        end
      endcase
      lamps_s = lamp_map(state_s);
    end
  end

  // State, countdown, blink toggle and lamp registers; clr forces lamps off.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= IDLE;
      count_r <= 8'd0;
      blink_r <= 1'b0;
      lamps_r <= 6'b000_000;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      blink_r <= blink_s;
      lamps_r <= lamps_s;
    end
  end

  assign {hr, hy, hg, vr, vy, vg} = lamps_r;
  assign count = count_r;

endmodule

// File: tb/tb_traffic_light.sv
// Directed-vector bench for traffic_light: vector table plus hand-written
// sequences for long runs, mid-phase interruptions and the mode walk.
module tb_traffic_light;

  logic       clk = 1'b0;
  logic       clr, test, flicker;
  logic       hr, hy, hg, vr, vy, vg;
  logic [7:0] count;

  int nvec = 0;
  int nerr = 0;

  localparam logic [5:0] L_OFF  = 6'b000_000;
  localparam logic [5:0] L_ALL  = 6'b111_111;
  localparam logic [5:0] L_HG   = 6'b001_100;
  localparam logic [5:0] L_HY   = 6'b010_100;
  localparam logic [5:0] L_VG   = 6'b100_001;
  localparam logic [5:0] L_VY   = 6'b100_010;
  localparam logic [5:0] L_FLSH = 6'b010_010;

  traffic_light dut (
    .clk(clk), .clr(clr), .test(test), .flicker(flicker),
    .hr(hr), .hy(hy), .hg(hg), .vr(vr), .vy(vy), .vg(vg), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c;
    logic       t;
    logic       f;
    logic [5:0] lamps;
    logic [7:0] cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [5:0] el, input logic [7:0] ec);
    nvec++;
    if ({hr, hy, hg, vr, vy, vg} !== el || count !== ec) begin
      nerr++;
      $display("FAIL %s: got lamps=%b count=%0d, want lamps=%b count=%0d",
               nm, {hr, hy, hg, vr, vy, vg}, count, el, ec);
    end
  endtask

  task automatic step(input logic c, input logic t, input logic f);
    clr = c; test = t; flicker = f;
    @(posedge clk);
    #1;
  endtask

  // Expected normal-mode output for the k-th normal edge (k >= 1) after a restart.
  function automatic logic [13:0] model(input int k);
    int p;
    p = (k - 1) % 60;
    if (p < 25)      model = {L_HG, 8'(25 - p)};
    else if (p < 30) model = {L_HY, 8'(30 - p)};
    else if (p < 55) model = {L_VG, 8'(55 - p)};
    else             model = {L_VY, 8'(60 - p)};
  endfunction

  vec_t vt[12];

  initial begin
    logic [13:0] m;
    int nk;
    logic fp;

    vt[0]  = '{1'b0, 1'b1, 1'b0, L_OFF,  8'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, L_ALL,  8'd88};
    vt[2]  = '{1'b1, 1'b0, 1'b1, L_ALL,  8'd88};
    vt[3]  = '{1'b1, 1'b1, 1'b0, L_HG,   8'd25};
    vt[4]  = '{1'b1, 1'b1, 1'b0, L_HG,   8'd24};
    vt[5]  = '{1'b1, 1'b1, 1'b1, L_FLSH, 8'd0};
    vt[6]  = '{1'b1, 1'b1, 1'b1, L_OFF,  8'd0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, L_FLSH, 8'd0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, L_HG,   8'd25};
    vt[9]  = '{1'b1, 1'b1, 1'b0, L_HG,   8'd24};
    vt[10] = '{1'b0, 1'b1, 1'b0, L_OFF,  8'd0};
    vt[11] = '{1'b1, 1'b1, 1'b0, L_HG,   8'd25};

    clr = 1'b0; test = 1'b1; flicker = 1'b0;
    #1;
    chk("reset_async", L_OFF, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i[0], i[1]);
      chk("reset_hold", L_OFF, 8'd0);
    end

    for (int i = 0; i < 12; i++) begin
      step(vt[i].c, vt[i].t, vt[i].f);
      chk($sformatf("vec%0d", i), vt[i].lamps, vt[i].cnt);
    end

    // Full normal run from a clean release.
    step(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b1, 1'b0);
      m = model(k);
      chk($sformatf("run_k%0d", k), m[13:8], m[7:0]);
    end

    // 20-cycle flash, then drop flicker.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b1);
      chk($sformatf("flash_k%0d", k), (k % 2 == 0) ? L_FLSH : L_OFF, 8'd0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("flash_exit", L_HG, 8'd25);

    // Lamp test during VG at count 12 restarts at HG, not VG.
    for (int k = 2; k <= 44; k++) step(1'b1, 1'b1, 1'b0);
    chk("vg_at_12", L_VG, 8'd12);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("mid_test", L_ALL, 8'd88);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("test_exit", L_HG, 8'd25);

    // clr pulsed between edges during HY clears outputs immediately.
    for (int k = 2; k <= 27; k++) step(1'b1, 1'b1, 1'b0);
    chk("in_hy", L_HY, 8'd4);
    #2;
    clr = 1'b0;
    #1;
    chk("clr_immediate", L_OFF, 8'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("clr_hold", L_OFF, 8'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_exit", L_HG, 8'd25);

    // Walk all clr/test/flicker combinations with a reference priority model.
    nk = 1;
    fp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 10; k++) begin
        step(i[2], i[1], i[0]);
        if (!i[2]) begin
          nk = 0; fp = 1'b0;
          chk($sformatf("walk%0d_clr", i), L_OFF, 8'd0);
        end else if (!i[1]) begin
          nk = 0; fp = 1'b0;
          chk($sformatf("walk%0d_test", i), L_ALL, 8'd88);
        end else if (i[0]) begin
          nk = 0; fp = ~fp;
          chk($sformatf("walk%0d_flash", i), fp ? L_FLSH : L_OFF, 8'd0);
        end else begin
          nk++; fp = 1'b0;
          m = model(nk);
          chk($sformatf("walk%0d_norm", i), m[13:8], m[7:0]);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
